n64_snac_poller: RTL and testbench
==================================

N64_SNAC_POLLER -- requirements
Module: n64_snac_poller

Interface
REQ-001 SHALL provide parameter RETRY_LIMIT, default 3, meaning consecutive read timeouts before the pad is declared absent (range 1..15).
REQ-002 SHALL provide parameter GAP_CYCLES, default 64, meaning the idle-high guard interval in clk_1x cycles after every transaction (range 1..255).
REQ-003 SHALL have port clk_1x  in  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port poll_req  in  1  one-cycle request to poll the pad (e.g. once per frame).
REQ-006 SHALL have port drv_ready  in  1  SNAC line driver idle / next-byte-ready flag.
REQ-007 SHALL have port drv_byteRec  in  1  one-cycle pulse: a received byte is valid on drv_dataIn.
REQ-008 SHALL have port drv_dataIn  in  8  received byte from the driver.
REQ-009 SHALL have port drv_timeout  in  1  one-cycle pulse: the pad did not answer.
REQ-010 SHALL have port drv_start  out  1  one-cycle transaction start to the driver.
REQ-011 SHALL have port drv_cmdData  out  8  command byte, held stable for the whole transaction.
REQ-012 SHALL have port drv_toPad_ena  out  1  next-byte strobe; tied 0 (single-byte commands only).
REQ-013 SHALL have port drv_sendCnt  out  6  bytes to send; constant 1.
REQ-014 SHALL have port drv_receiveCnt  out  6  bytes expected: 3 for identify, 4 for read.
REQ-015 SHALL have port pad_present  out  1  pad identified and answering.
REQ-016 SHALL have port pad_type  out  16  first two identify bytes, first byte in [15:8].
REQ-017 SHALL have port buttons  out  32  last good read, first byte in [31:24].
REQ-018 SHALL have port buttons_valid  out  1  one-cycle pulse when buttons updates.
REQ-019 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-020 SHALL implement the states IDLE, START, WAIT_ACK, RECV and GAP.
REQ-021 SHALL, in IDLE on (poll_req or pending) with drv_ready=1, select the command (0x00 identify if pad_present=0, else 0x01 read), clear pending, and go to START.
REQ-022 SHALL, in START, assert drv_start for exactly one cycle and go to WAIT_ACK.
REQ-023 SHALL, in WAIT_ACK, go to RECV once drv_ready=0; if drv_ready is still 1 after 4 cycles, return to START (retry the start pulse).
REQ-024 SHALL, in RECV, store drv_dataIn into byte slot byte_cnt on each drv_byteRec and increment the 3-bit byte_cnt.
REQ-025 SHALL complete the transaction when byte_cnt reaches drv_receiveCnt, committing results in the following cycle.
REQ-026 SHALL, on identify completion: set pad_present=1, set pad_type={byte0,byte1}, and reset miss_cnt to 0.
REQ-027 SHALL, on read completion: load all 32 bits of buttons in the same cycle, pulse buttons_valid for one cycle, and reset miss_cnt to 0.
REQ-028 SHALL, on drv_timeout in RECV: abandon the transaction and discard any partial bytes; if the command was a read, increment miss_cnt, saturating at 15.
REQ-029 SHALL, when miss_cnt reaches RETRY_LIMIT: clear pad_present, clear buttons to 0, and leave pad_type unchanged.
REQ-030 SHALL treat a completed identify with no timeout as success regardless of the returned byte values.
REQ-031 SHALL, after completion or timeout, enter GAP, count GAP_CYCLES, then return to IDLE.
REQ-032 SHALL set pending on poll_req received in any state other than IDLE; further requests while pending=1 merge into it; pending is serviced from IDLE.
REQ-033 SHALL ignore drv_byteRec and drv_timeout outside RECV.
REQ-034 SHALL, when drv_byteRec and drv_timeout coincide in RECV, give the timeout priority.
REQ-035 SHALL drive all outputs from registers.

Reset
REQ-036 SHALL, on reset, force state=IDLE, and set drv_start=0, drv_cmdData=0x00, drv_receiveCnt=3, pad_present=0, pad_type=0, buttons=0, buttons_valid=0, busy=0, pending=0, miss_cnt=0, byte_cnt=0.
REQ-037 SHALL give reset priority over all other inputs, aborting any transaction with no commit.

Verification
REQ-038 SHALL cover: after reset, poll_req, driver model returns 0x05,0x00,0x01 -> drv_cmdData=0x00, drv_receiveCnt=3, pad_present=1, pad_type=0x0500.
REQ-039 SHALL cover: pad present, poll_req, model returns 0x80,0x00,0x12,0xF0 -> drv_cmdData=0x01, buttons=0x800012F0, buttons_valid high exactly 1 cycle.
REQ-040 SHALL cover: pad present, 3 consecutive read timeouts -> pad_present=0 and buttons=0 after the 3rd; the next poll_req issues 0x00.
REQ-041 SHALL cover: 2 timeouts then a good read -> miss_cnt=0 and pad_present stays 1.
REQ-042 SHALL cover: two poll_req pulses during a busy read -> exactly one further transaction, started after the GAP.
REQ-043 SHALL cover: reset asserted after 2 of 4 read bytes -> buttons unchanged (0), no buttons_valid, FSM in IDLE.

Source files
------------

// File: rtl/n64_snac_poller.sv
// N64 pad poller: drives a SNAC line driver with identify/read commands,
// tracks pad presence over consecutive read timeouts and latches button state.
module n64_snac_poller #(
  parameter int RETRY_LIMIT = 3,
  parameter int GAP_CYCLES  = 64
) (
  input  logic        clk_1x,
  input  logic        reset,
  input  logic        poll_req,
  input  logic        drv_ready,
  input  logic        drv_byteRec,
  input  logic [7:0]  drv_dataIn,
  input  logic        drv_timeout,
  output logic        drv_start,
  output logic [7:0]  drv_cmdData,
  output logic        drv_toPad_ena,
  output logic [5:0]  drv_sendCnt,
  output logic [5:0]  drv_receiveCnt,
  output logic        pad_present,
  output logic [15:0] pad_type,
  output logic [31:0] buttons,
  output logic        buttons_valid,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, START, WAIT_ACK, RECV, GAP} state_t;

  localparam logic [3:0] RETRY_L = 4'(RETRY_LIMIT);
  localparam logic [7:0] GAP_L   = 8'(GAP_CYCLES - 1);

  state_t          state, state_nxt;
  logic            pending;
  logic [3:0]      miss_cnt, miss_inc;
  logic [2:0]      byte_cnt;
  logic [1:0]      wait_cnt;
  logic [7:0]      gap_cnt;
  logic [3:0][7:0] rx_bytes;
  logic            launch, rx_to, rx_done, is_read;

  assign drv_toPad_ena = 1'b0;
  assign drv_sendCnt   = 6'd1;

  assign is_read  = drv_cmdData[0];
  assign launch   = (state == IDLE) && (poll_req || pending) && drv_ready;
  assign rx_to    = (state == RECV) && drv_timeout;
  assign rx_done  = (state == RECV) && !drv_timeout && ({3'd0, byte_cnt} == drv_receiveCnt);
  assign miss_inc = (miss_cnt == 4'd15) ? 4'd15 : miss_cnt + 4'd1;

  always_ff @(posedge clk_1x) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (launch) state_nxt = START;
      START:    state_nxt = WAIT_ACK;
      // driver never dropped ready: pulse start again
      WAIT_ACK: if (!drv_ready) state_nxt = RECV;
                else if (wait_cnt == 2'd3) state_nxt = START;
      RECV:     if (rx_to || rx_done) state_nxt = GAP;
      GAP:      if (gap_cnt == GAP_L) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_1x) begin
    if (reset) begin
      drv_start      <= 1'b0;
      drv_cmdData    <= 8'h00;
      drv_receiveCnt <= 6'd3;
      pad_present    <= 1'b0;
      pad_type       <= 16'h0000;
      buttons        <= 32'h0;
      buttons_valid  <= 1'b0;
      busy           <= 1'b0;
      pending        <= 1'b0;
      miss_cnt       <= 4'd0;
      byte_cnt       <= 3'd0;
      wait_cnt       <= 2'd0;
      gap_cnt        <= 8'd0;
      rx_bytes       <= '0;
    end else begin
      drv_start     <= (state_nxt == START);
      busy          <= (state_nxt != IDLE);
      buttons_valid <= 1'b0;
      wait_cnt      <= (state == WAIT_ACK) ? wait_cnt + 2'd1 : 2'd0;
      gap_cnt       <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;

      if (launch)        pending <= 1'b0;
      else if (poll_req) pending <= 1'b1;

      if (launch) begin
        drv_cmdData    <= pad_present ? 8'h01 : 8'h00;
        drv_receiveCnt <= pad_present ? 6'd4 : 6'd3;
        byte_cnt       <= 3'd0;
      end

      if (state == RECV && drv_byteRec && !drv_timeout && !rx_done && !byte_cnt[2]) begin
        rx_bytes[byte_cnt[1:0]] <= drv_dataIn;
        byte_cnt                <= byte_cnt + 3'd1;
      end

      if (rx_to) begin
        byte_cnt <= 3'd0;
        if (is_read) begin
          miss_cnt <= miss_inc;
          if (miss_inc >= RETRY_L) begin
            pad_present <= 1'b0;
            buttons     <= 32'h0;
          end
        end
      end else if (rx_done) begin
        miss_cnt <= 4'd0;
        if (is_read) begin
          buttons       <= {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]};
          buttons_valid <= 1'b1;
        end else begin
          pad_present <= 1'b1;
          pad_type    <= {rx_bytes[0], rx_bytes[1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_n64_snac_poller.sv
// Directed bench for n64_snac_poller with a small procedural SNAC driver model.
module tb_n64_snac_poller;
  localparam int GAP = 8;

  logic        clk_1x = 1'b0;
  logic        reset;
  logic        poll_req, drv_ready, drv_byteRec, drv_timeout;
  logic [7:0]  drv_dataIn;
  logic        drv_start, drv_toPad_ena, pad_present, buttons_valid, busy;
  logic [7:0]  drv_cmdData;
  logic [5:0]  drv_sendCnt, drv_receiveCnt;
  logic [15:0] pad_type;
  logic [31:0] buttons;

  int n_cmp = 0, n_bad = 0;
  int bv_cnt = 0, st_cnt = 0;
  int bv0, st0, k;

  n64_snac_poller #(.RETRY_LIMIT(3), .GAP_CYCLES(GAP)) dut (
    .clk_1x(clk_1x), .reset(reset), .poll_req(poll_req), .drv_ready(drv_ready),
    .drv_byteRec(drv_byteRec), .drv_dataIn(drv_dataIn), .drv_timeout(drv_timeout),
    .drv_start(drv_start), .drv_cmdData(drv_cmdData), .drv_toPad_ena(drv_toPad_ena),
    .drv_sendCnt(drv_sendCnt), .drv_receiveCnt(drv_receiveCnt), .pad_present(pad_present),
    .pad_type(pad_type), .buttons(buttons), .buttons_valid(buttons_valid), .busy(busy)
  );

  always #5 clk_1x = ~clk_1x;

  always @(posedge clk_1x) begin
    if (buttons_valid) bv_cnt++;
    if (drv_start)     st_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_1x); #1;
  endtask

  task automatic poll();
    poll_req = 1'b1; step(); poll_req = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (drv_start) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) chk({tag, "_start_seen"}, {31'd0, drv_start}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) chk({tag, "_idle_seen"}, {31'd0, busy}, 32'd0);
  endtask

  // Driver model: drop ready, deliver n bytes MSB-first, optionally time out.
  task automatic do_rx(input int n, input logic [31:0] d, input bit to);
    drv_ready = 1'b0; step(); step();
    for (int i = 0; i < n; i++) begin
      drv_dataIn = d[31-8*i -: 8]; drv_byteRec = 1'b1; step();
      drv_byteRec = 1'b0; step();
    end
    if (to) begin drv_timeout = 1'b1; step(); drv_timeout = 1'b0; end
    drv_ready = 1'b1;
  endtask

  task automatic identify(input string tag);
    poll(); wait_start(tag);
    chk({tag, "_cmd"}, {24'd0, drv_cmdData}, 32'h00);
    chk({tag, "_rcnt"}, {26'd0, drv_receiveCnt}, 32'd3);
    do_rx(3, 32'h05000100, 1'b0); wait_idle(tag);
    chk({tag, "_present"}, {31'd0, pad_present}, 32'd1);
  endtask

  task automatic read_ok(input string tag, input logic [31:0] d);
    bv0 = bv_cnt;
    poll(); wait_start(tag);
    chk({tag, "_cmd"}, {24'd0, drv_cmdData}, 32'h01);
    do_rx(4, d, 1'b0); wait_idle(tag); step();
    chk({tag, "_buttons"}, buttons, d);
    chk({tag, "_bv_pulses"}, bv_cnt - bv0, 32'd1);
  endtask

  task automatic read_to(input string tag);
    poll(); wait_start(tag);
    chk({tag, "_cmd"}, {24'd0, drv_cmdData}, 32'h01);
    do_rx(1, 32'hAA000000, 1'b1); wait_idle(tag);
  endtask

  initial begin
    reset = 1'b1; poll_req = 1'b0; drv_ready = 1'b1; drv_byteRec = 1'b0;
    drv_timeout = 1'b0; drv_dataIn = 8'h00;
    step(); step(); step();
    reset = 1'b0;
    chk("rst_start", {31'd0, drv_start}, 32'd0);
    chk("rst_cmd", {24'd0, drv_cmdData}, 32'h00);
    chk("rst_rcnt", {26'd0, drv_receiveCnt}, 32'd3);
    chk("rst_present", {31'd0, pad_present}, 32'd0);
    chk("rst_type", {16'd0, pad_type}, 32'd0);
    chk("rst_buttons", buttons, 32'd0);
    chk("rst_bv", {31'd0, buttons_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("const_send", {26'd0, drv_sendCnt}, 32'd1);
    chk("const_topad", {31'd0, drv_toPad_ena}, 32'd0);

    identify("id1");
    chk("id1_type", {16'd0, pad_type}, 32'h0500);

    read_ok("rd1", 32'h800012F0);

    read_to("to1");
    chk("to1_present", {31'd0, pad_present}, 32'd1);
    chk("to1_buttons", buttons, 32'h800012F0);
    read_to("to2");
    chk("to2_present", {31'd0, pad_present}, 32'd1);
    read_to("to3");
    chk("to3_present", {31'd0, pad_present}, 32'd0);
    chk("to3_buttons", buttons, 32'd0);
    chk("to3_type", {16'd0, pad_type}, 32'h0500);
    identify("id2");

    // two misses, a good read, then two more misses must not drop the pad
    read_to("m1"); read_to("m2");
    read_ok("rd2", 32'h00FF1234);
    chk("rd2_present", {31'd0, pad_present}, 32'd1);
    read_to("m3"); read_to("m4");
    chk("m4_present", {31'd0, pad_present}, 32'd1);
    read_ok("rd3", 32'h12345678);

    // start retry when the driver never drops ready
    poll(); wait_start("rty");
    step(); step(); step(); step();
    chk("rty_no_start", {31'd0, drv_start}, 32'd0);
    step();
    chk("rty_restart", {31'd0, drv_start}, 32'd1);
    do_rx(4, 32'hCAFEF00D, 1'b0); wait_idle("rty");
    chk("rty_buttons", buttons, 32'hCAFEF00D);

    // two requests while busy merge into one follow-up after the gap
    st0 = st_cnt;
    poll(); wait_start("pend");
    drv_ready = 1'b0; step(); step();
    poll_req = 1'b1; step(); poll_req = 1'b0; step();
    poll_req = 1'b1; step(); poll_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv_dataIn = 8'h11 * (i + 1); drv_byteRec = 1'b1; step();
      drv_byteRec = 1'b0; step();
    end
    drv_ready = 1'b1;
    chk("pend_buttons", buttons, 32'h11223344);
    for (k = 1; k <= 30; k++) begin
      step();
      if (drv_start) break;
    end
    chk("pend_start_delay", k, GAP + 1);
    chk("pend_cmd", {24'd0, drv_cmdData}, 32'h01);
    do_rx(4, 32'h55667788, 1'b0); wait_idle("pend2");
    for (int i = 0; i < 3 * GAP; i++) step();
    chk("pend_starts", st_cnt - st0, 32'd2);
    chk("pend_buttons2", buttons, 32'h55667788);

    // reset in the middle of a read
    reset = 1'b1; step(); reset = 1'b0;
    identify("id3");
    bv0 = bv_cnt;
    poll(); wait_start("mid");
    drv_ready = 1'b0; step(); step();
    for (int i = 0; i < 2; i++) begin
      drv_dataIn = 8'h9A; drv_byteRec = 1'b1; step();
      drv_byteRec = 1'b0; step();
    end
    reset = 1'b1; step(); step(); reset = 1'b0; drv_ready = 1'b1; step(); step();
    chk("mid_buttons", buttons, 32'd0);
    chk("mid_bv", bv_cnt - bv0, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_present", {31'd0, pad_present}, 32'd0);
    poll(); wait_start("mid_next");
    chk("mid_next_cmd", {24'd0, drv_cmdData}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
